// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - register offsets and CLAIM field layout for the IRQ aggregator
package irq_pkg;

    localparam int NSRC_MAX = 16;

    localparam logic [2:0] ADDR_RAW     = 3'd0;
    localparam logic [2:0] ADDR_ENABLE  = 3'd1;
    localparam logic [2:0] ADDR_PENDING = 3'd2;
    localparam logic [2:0] ADDR_MODE    = 3'd3;
    localparam logic [2:0] ADDR_CLAIM   = 3'd4;
    localparam logic [2:0] ADDR_SOFT    = 3'd5;

    localparam int CLAIM_IDX_LSB   = 0;
    localparam int CLAIM_IDX_MSB   = 4;
    localparam int CLAIM_VALID_BIT = 31;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchroniser plus delay flop for rising-edge detect
module irq_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_src,
    output logic o_level,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // s3 clears with reset so the first post-reset cycle cannot fake a rise
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_src;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/apb_irq_aggregator.sv
// rtl/apb_irq_aggregator.sv - APB3 interrupt aggregator with enable/pending/mode/claim/soft registers
module apb_irq_aggregator
    import irq_pkg::*;
#(
    parameter int NSRC        = 8,
    parameter bit IRQ_ACTIVEH = 1'b1
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic            PSEL,
    input  logic            PENABLE,
    input  logic            PWRITE,
    input  logic [4:2]      PADDR,
    input  logic [31:0]     PWDATA,
    output logic [31:0]     PRDATA,
    input  logic [NSRC-1:0] SRC,
    output logic            IRQ
);

    logic [NSRC-1:0] r_enable;
    logic [NSRC-1:0] r_mode;
    logic [NSRC-1:0] r_pending;
    logic            r_irq;

    logic [NSRC-1:0] w_level;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_soft;
    logic [NSRC-1:0] w_clr;
    logic [NSRC-1:0] w_set;
    logic [NSRC-1:0] w_active;
    logic [31:0]     w_claim;
    logic [31:0]     w_rdata;
    logic            w_wr;
    logic            w_unused;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        irq_sync_edge u_sync (
            .i_clk   (PCLK),
            .i_rst   (PRESET),
            .i_src   (SRC[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_wr     = PSEL & PENABLE & PWRITE;
    assign w_soft   = (w_wr && PADDR == ADDR_SOFT)    ? PWDATA[NSRC-1:0] : '0;
    assign w_clr    = (w_wr && PADDR == ADDR_PENDING) ? PWDATA[NSRC-1:0] : '0;
    assign w_set    = (r_mode & w_rise) | (~r_mode & w_level) | w_soft;
    assign w_active = r_pending & r_enable;
    assign w_unused = ^PWDATA[31:NSRC];

    // set beats clear, so a still-high level source re-pends on the same edge
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_enable  <= '0;
            r_mode    <= '0;
            r_pending <= '0;
            r_irq     <= ~IRQ_ACTIVEH;
        end else begin
            if (w_wr && PADDR == ADDR_ENABLE) r_enable <= PWDATA[NSRC-1:0];
            if (w_wr && PADDR == ADDR_MODE)   r_mode   <= PWDATA[NSRC-1:0];
            r_pending <= w_set | (r_pending & ~w_clr);
            r_irq     <= IRQ_ACTIVEH ? (|w_active) : ~(|w_active);
        end
    end

    assign IRQ = r_irq;

    always_comb begin
        w_claim = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_claim[CLAIM_VALID_BIT]             = 1'b1;
                w_claim[CLAIM_IDX_MSB:CLAIM_IDX_LSB] = 5'(i);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                ADDR_RAW:     w_rdata = 32'(w_level);
                ADDR_ENABLE:  w_rdata = 32'(r_enable);
                ADDR_PENDING: w_rdata = 32'(r_pending);
                ADDR_MODE:    w_rdata = 32'(r_mode);
                ADDR_CLAIM:   w_rdata = w_claim;
                default:      w_rdata = '0;
            endcase
        end
    end

    assign PRDATA = w_rdata;

endmodule

// File: tb/tb_apb_irq_aggregator.sv
// tb/tb_apb_irq_aggregator.sv - scoreboard bench for both IRQ polarities of apb_irq_aggregator
module tb_apb_irq_aggregator;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:2]  PADDR;
    logic [31:0] PWDATA;
    logic [7:0]  SRC;
    logic [31:0] prdata;
    logic [31:0] prdata_n;
    logic        irq;
    logic        irq_n;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    localparam logic [2:0] A_RAW = 3'd0, A_EN = 3'd1, A_PEND = 3'd2, A_MODE = 3'd3,
                           A_CLAIM = 3'd4, A_SOFT = 3'd5;

    apb_irq_aggregator #(.NSRC(8), .IRQ_ACTIVEH(1'b1)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata), .SRC(SRC), .IRQ(irq)
    );

    apb_irq_aggregator #(.NSRC(8), .IRQ_ACTIVEH(1'b0)) dut_n (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata_n), .SRC(SRC), .IRQ(irq_n)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [2:0] a, input logic [31:0] d);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
    endtask

    task automatic expect_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        exp_q.push_back(exp);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        #1;
        e = exp_q.pop_front();
        check(tag, prdata, e);
        e = exp_q.pop_front();
        check({tag, "_n"}, prdata_n, e);
        PSEL = 1'b0;
    endtask

    task automatic expect_irq(input string tag, input logic exp);
        logic [31:0] e;
        exp_q.push_back({31'b0, exp});
        exp_q.push_back({31'b0, ~exp});
        e = exp_q.pop_front();
        check({tag, "_irq"}, {31'b0, irq}, e);
        e = exp_q.pop_front();
        check({tag, "_irqn"}, {31'b0, irq_n}, e);
    endtask

    initial begin
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; SRC = '0;
        tick(); tick();
        expect_irq("in_reset", 1'b0);
        PRESET = 1'b0;
        tick();
        expect_irq("after_reset", 1'b0);
        expect_rd("rst_raw", A_RAW, 32'h0);
        expect_rd("rst_en", A_EN, 32'h0);
        expect_rd("rst_pend", A_PEND, 32'h0);
        expect_rd("rst_mode", A_MODE, 32'h0);
        expect_rd("rst_claim", A_CLAIM, 32'h0);

        // edge mode pulse on source 0
        apb_write(A_EN, 32'h01);
        apb_write(A_MODE, 32'h01);
        SRC[0] = 1'b1;
        tick();
        SRC[0] = 1'b0;
        expect_rd("e_k", A_PEND, 32'h0);
        tick();
        expect_rd("e_k1", A_PEND, 32'h0);
        expect_irq("e_k1", 1'b0);
        tick();
        expect_rd("e_k2", A_PEND, 32'h01);
        expect_irq("e_k2", 1'b0);
        tick();
        expect_irq("e_k3", 1'b1);
        expect_rd("e_claim", A_CLAIM, 32'h8000_0000);
        apb_write(A_PEND, 32'h01);
        expect_rd("e_w1c", A_PEND, 32'h0);
        expect_irq("e_w1c_same", 1'b1);
        tick();
        expect_irq("e_w1c_next", 1'b0);

        // level mode on source 2
        apb_write(A_MODE, 32'h00);
        apb_write(A_EN, 32'h04);
        SRC[2] = 1'b1;
        tick(); tick(); tick();
        expect_rd("l_pend", A_PEND, 32'h04);
        expect_rd("l_raw", A_RAW, 32'h04);
        tick();
        expect_irq("l_irq", 1'b1);
        apb_write(A_PEND, 32'h04);
        expect_rd("l_w1c_held", A_PEND, 32'h04);
        SRC[2] = 1'b0;
        tick(); tick(); tick();
        apb_write(A_PEND, 32'h04);
        expect_rd("l_w1c_drop", A_PEND, 32'h0);
        tick();
        expect_irq("l_clear", 1'b0);

        // soft set and claim priority
        apb_write(A_EN, 32'h20);
        apb_write(A_SOFT, 32'h30);
        expect_rd("s_pend", A_PEND, 32'h30);
        expect_rd("s_claim5", A_CLAIM, 32'h8000_0005);
        expect_rd("s_soft_rd", A_SOFT, 32'h0);
        tick();
        expect_irq("s_irq", 1'b1);
        apb_write(A_EN, 32'h30);
        expect_rd("s_claim4", A_CLAIM, 32'h8000_0004);
        apb_write(A_PEND, 32'h30);
        tick();
        expect_irq("s_clear", 1'b0);

        // edge set collides with W1C, then MODE change
        apb_write(A_MODE, 32'h02);
        apb_write(A_EN, 32'h02);
        SRC[1] = 1'b1;
        tick();
        apb_write(A_PEND, 32'h02);
        expect_rd("c_collide", A_PEND, 32'h02);
        tick();
        apb_write(A_PEND, 32'h02);
        expect_rd("c_w1c", A_PEND, 32'h0);
        apb_write(A_MODE, 32'h00);
        expect_rd("c_mode_hold", A_PEND, 32'h0);
        tick();
        expect_rd("c_mode_level", A_PEND, 32'h02);
        SRC[1] = 1'b0;
        tick(); tick(); tick();
        apb_write(A_PEND, 32'h02);
        expect_rd("c_final", A_PEND, 32'h0);
        tick();
        expect_irq("c_final", 1'b0);

        // upper bits ignored, then reset aborting a write
        apb_write(A_EN, 32'hFFFF_FFFF);
        expect_rd("r_en_mask", A_EN, 32'h0000_00FF);
        apb_write(A_SOFT, 32'hFF);
        tick();
        expect_rd("r_pend_ff", A_PEND, 32'hFF);
        expect_irq("r_pre", 1'b1);
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = A_MODE; PWDATA = 32'hFF;
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
        expect_irq("r_post", 1'b0);
        expect_rd("r_en", A_EN, 32'h0);
        expect_rd("r_pend", A_PEND, 32'h0);
        expect_rd("r_mode", A_MODE, 32'h0);
        expect_rd("r_claim", A_CLAIM, 32'h0);
        PADDR = A_EN;
        #1;
        check("r_idle_rd", prdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_irq_aggregator.md
APB_IRQ_AGGREGATOR -- requirements
Module: apb_irq_aggregator

Interface
REQ-001 Parameter NSRC, default 8: number of interrupt sources, 1..16; source 0 carries TIMINT from the timer instance.
REQ-002 Parameter IRQ_ACTIVEH, default 1: 1 drives IRQ active-high, 0 drives it active-low.
REQ-003 PCLK  in  1  single clock; all state updates on its rising edge.
REQ-004 PRESET  in  1  reset, synchronous and active-high.
REQ-005 PSEL, PENABLE, PWRITE  in  1 each  APB3 control signals; no PREADY port, zero wait states.
REQ-006 PADDR  in  [4:2]  word address of the register.
REQ-007 PWDATA  in  32  write data. PRDATA  out  32  read data.
REQ-008 SRC  in  NSRC  interrupt sources, asynchronous to PCLK, active-high.
REQ-009 IRQ  out  1  aggregated interrupt request to the CPU, driven from a register.

Function
REQ-010 Register map (PADDR[4:2]): 0 RAW (RO, synchronised SRC), 1 ENABLE (RW), 2 PENDING (RO; write-1-to-clear), 3 MODE (RW; bit=1 edge, 0 level), 4 CLAIM (RO), 5 SOFT (WO; write-1-to-set PENDING); bits at NSRC and above read 0 and ignore writes.
REQ-011 Write takes effect on the PCLK edge where PSEL&PENABLE&PWRITE=1; writes to addresses 4, 6 and 7 have no effect.
REQ-012 PRDATA is combinational from the register state whenever PSEL=1 and PWRITE=0, and is 0 otherwise; reads have no side effects.
REQ-013 Each SRC bit passes through a two-flop synchroniser (s1, s2) plus a delay flop s3.
REQ-014 Edge mode: s2&~s3 sets the PENDING bit. Level mode: s2=1 sets the PENDING bit every cycle.
REQ-015 Priority of PENDING updates, per bit, highest first: set from the source or SOFT, then W1C clear, then hold. A clear while the level source is still high is therefore overridden on the same edge.
REQ-016 A MODE write takes effect on the next edge and leaves PENDING unchanged.
REQ-017 IRQ_int = |(PENDING & ENABLE), registered; IRQ = IRQ_int when IRQ_ACTIVEH=1, and ~IRQ_int otherwise.
REQ-018 Latency: SRC rising before edge k sets PENDING at edge k+2 and asserts IRQ at edge k+3.
REQ-019 IRQ deasserts one edge after the last enabled pending bit clears, or after its ENABLE bit is cleared.
REQ-020 CLAIM[4:0] is the lowest index i with PENDING[i]&ENABLE[i]; CLAIM[31] is valid; all of CLAIM reads 0 if no enabled bit is pending.
REQ-021 PENDING bits with ENABLE=0 still latch and are visible in the PENDING register.

Reset
REQ-022 When PRESET=1 at an edge: ENABLE, PENDING, MODE, s1, s2 and s3 are 0, and IRQ_int is 0, so IRQ is inactive for the selected polarity.
REQ-023 Reset asserted mid-transfer aborts the transfer; a write in progress has no effect.
REQ-024 The first edge after PRESET deasserts cannot produce a false edge detect, because s3 is 0 and SRC is synchronised through s1 and s2 again.

Structure
REQ-025 A shared package irq_pkg holds the register offset constants, NSRC_MAX=16 and the CLAIM field positions.
REQ-026 One sub-module, irq_sync_edge (per-bit synchroniser plus edge detector), is instantiated NSRC times.
REQ-027 Target size is 150-300 lines of RTL; no RAMs, no latches.

Verification
REQ-028 Reset, then ENABLE=0x01 and MODE=0x01; pulse SRC[0] high for 1 cycle -> PENDING=0x01 at k+2, IRQ=1 at k+3; write PENDING=0x01 -> IRQ=0 one edge later.
REQ-029 Level mode, SRC[2] held high, ENABLE=0x04; write PENDING=0x04 -> PENDING reads 0x04 again; drop SRC[2], then write PENDING=0x04 -> PENDING=0, IRQ=0.
REQ-030 SOFT=0x30, ENABLE=0x20 -> CLAIM=0x80000005, IRQ=1; set ENABLE=0x30 -> CLAIM=0x80000004.
REQ-031 Edge on SRC[1] in the same cycle as a W1C of bit 1 -> PENDING[1] stays 1.
REQ-032 IRQ_ACTIVEH=0 -> IRQ=1 during and after reset, and IRQ=0 while any enabled bit is pending.
REQ-033 Assert PRESET for one cycle while PENDING=0xFF and IRQ=1 -> the next edge shows all registers 0, IRQ inactive and PRDATA=0 on reads.
